// File: rtl/hdmi_di_pkg.sv
// Shared definitions for the HDMI data-island receive path.
// Holds the packet type codes, the BCH generator and the one-bit BCH LFSR step.
// Purely combinational content; no latency or flow-control behaviour of its own.
package hdmi_di_pkg;

    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
    localparam logic [7:0] PKT_AVI   = 8'h82;
    localparam logic [7:0] PKT_AIF   = 8'h84;

    localparam logic [7:0] BCH_POLY  = 8'hC1;

    typedef enum logic {
        AUD_IDLE = 1'b0,
        AUD_EMIT = 1'b1
    } audState_t;

    // One LFSR step: shift left, fold the generator in when feedback is set.
    function automatic logic [7:0] bch_step(input logic [7:0] code, input logic din);
        bch_step = {code[6:0], 1'b0} ^ ((code[7] ^ din) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_syndrome.sv
// One BCH syndrome lane: folds one or two bits per cycle into an 8-bit LFSR.
// Latency: syndrome is combinational and already includes the current cycle's bits.
// Backpressure: none; the lane advances on every cycle with en=1.
//
// Ports: i_pixclk/i_reset_n clock and async active-low reset; clr restarts the
// code from zero on this cycle; en advances the lane; bitEven is folded first,
// then bitOdd when dual=1; syndrome is the code after this cycle's bits.
module hdmi_bch_syndrome
    import hdmi_di_pkg::*;
(
    input  logic       i_pixclk,
    input  logic       i_reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bitEven,
    input  logic       bitOdd,
    input  logic       dual,
    output logic [7:0] syndrome
);

    logic [7:0] code;
    logic [7:0] base;
    logic [7:0] afterEven;

    // Clearing feeds zero into the first step so pos 0 starts a fresh codeword
    // without needing an extra idle cycle between packets.
    assign base      = clr ? 8'h00 : code;
    assign afterEven = bch_step(base, bitEven);
    assign syndrome  = dual ? bch_step(afterEven, bitOdd) : afterEven;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            code <= 8'h00;
        end else if (en) begin
            code <= syndrome;
        end
    end

endmodule

// File: rtl/hdmi_data_island_rx.sv
// HDMI data-island packet decoder: reassembles 32-cycle packets, BCH-checks them, extracts ACR/audio.
// Latency: sync 1 cycle, o_pkt_valid 1 after pos 31, ACR 2 after, audio sample k at 2+k after.
// Backpressure: none; the receiver follows the link and outputs are strobes.
//
// Ports: i_pixclk, i_reset_n (async, active low); i_data marks the island;
// i_d0/i_d1/i_d2 TERC4-decoded nibbles; o_hsync/o_vsync; o_pkt_* packet with
// o_hdr_ok/o_sub_ok status; o_pkt_drop for discarded partials; o_acr_valid,
// o_cts, o_n; o_audio_valid, o_audio_l, o_audio_r.
// Build option HDMI_DI_AUDIO_EXTRACT_EN enables ACR/audio extraction; without it
// those outputs are held at zero.
module hdmi_data_island_rx
    import hdmi_di_pkg::*;
#(
    parameter int PKT_LEN = 32
) (
    input  logic         i_pixclk,
    input  logic         i_reset_n,
    input  logic         i_data,
    input  logic [3:0]   i_d0,
    input  logic [3:0]   i_d1,
    input  logic [3:0]   i_d2,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_pkt_valid,
    output logic [23:0]  o_pkt_header,
    output logic [223:0] o_pkt_sub,
    output logic         o_hdr_ok,
    output logic [3:0]   o_sub_ok,
    output logic         o_pkt_drop,
    output logic         o_acr_valid,
    output logic [19:0]  o_cts,
    output logic [19:0]  o_n,
    output logic         o_audio_valid,
    output logic [15:0]  o_audio_l,
    output logic [15:0]  o_audio_r
);

    localparam logic [4:0] LAST_POS = 5'(PKT_LEN - 1);

    // pos holds the position expected for the current nibble; it is zero
    // whenever the island is idle, so a nonzero pos means a packet is underway.
    logic [4:0]       pos;
    logic [4:0]       curPos;
    logic             pktDone;
    logic             dropNow;
    logic [23:0]      hdrReg;
    logic [3:0][55:0] subReg;
    logic [7:0]       hdrSyn;
    logic [3:0][7:0]  subSyn;

    assign curPos  = i_d0[3] ? pos : 5'd0;
    assign pktDone = i_data && (curPos == LAST_POS);
    // Partial packet: island ends, or a resync arrives, while mid-packet.
    assign dropNow = (pos != 5'd0) && (!i_data || !i_d0[3]);

    hdmi_bch_syndrome u_hdrBch (
        .i_pixclk (i_pixclk),
        .i_reset_n(i_reset_n),
        .clr      (curPos == 5'd0),
        .en       (i_data),
        .bitEven  (i_d0[2]),
        .bitOdd   (1'b0),
        .dual     (1'b0),
        .syndrome (hdrSyn)
    );

    for (genvar k = 0; k < 4; k++) begin : g_subBch
        hdmi_bch_syndrome u_subBch (
            .i_pixclk (i_pixclk),
            .i_reset_n(i_reset_n),
            .clr      (curPos == 5'd0),
            .en       (i_data),
            .bitEven  (i_d1[k]),
            .bitOdd   (i_d2[k]),
            .dual     (1'b1),
            .syndrome (subSyn[k])
        );
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pos     <= 5'd0;
            hdrReg  <= '0;
            subReg  <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
        end else if (!i_data) begin
            pos <= 5'd0;
        end else begin
            pos     <= curPos + 5'd1;
            o_hsync <= i_d0[0];
            o_vsync <= i_d0[1];
            if (curPos < 5'd24) begin
                hdrReg[curPos] <= i_d0[2];
            end
            if (curPos < 5'd28) begin
                for (int k = 0; k < 4; k++) begin
                    subReg[k][{curPos, 1'b0}] <= i_d1[k];
                    subReg[k][{curPos, 1'b1}] <= i_d2[k];
                end
            end
        end
    end

    // Data bits are complete well before pos 31; the syndromes come straight
    // from the lanes so the pos-31 parity bits are included in the same cycle.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pkt_valid  <= 1'b0;
            o_pkt_drop   <= 1'b0;
            o_pkt_header <= '0;
            o_pkt_sub    <= '0;
            o_hdr_ok     <= 1'b0;
            o_sub_ok     <= 4'h0;
        end else begin
            o_pkt_valid <= pktDone;
            o_pkt_drop  <= dropNow;
            if (pktDone) begin
                o_pkt_header <= hdrReg;
                o_pkt_sub    <= subReg;
                o_hdr_ok     <= (hdrSyn == 8'h00);
                for (int k = 0; k < 4; k++) begin
                    o_sub_ok[k] <= (subSyn[k] == 8'h00);
                end
            end
        end
    end

`ifdef HDMI_DI_AUDIO_EXTRACT_EN
    logic      acrHit;
    logic      audStart;
    audState_t state;
    audState_t stateNxt;
    logic [1:0] emitIdx;
    logic [3:0] emitMask;
    logic [7:0] subBase;

    assign acrHit   = o_pkt_valid && (o_pkt_header[7:0] == PKT_ACR) && o_hdr_ok && o_sub_ok[0];
    assign audStart = o_pkt_valid && (o_pkt_header[7:0] == PKT_AUDIO) && o_hdr_ok;
    // Bit offset of subpacket emitIdx inside o_pkt_sub (idx * 56).
    assign subBase  = {emitIdx, 6'd0} - {3'd0, emitIdx, 3'd0};

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_acr_valid <= 1'b0;
            o_cts       <= '0;
            o_n         <= '0;
        end else begin
            o_acr_valid <= acrHit;
            if (acrHit) begin
                o_cts <= {o_pkt_sub[11:8], o_pkt_sub[23:16], o_pkt_sub[31:24]};
                o_n   <= {o_pkt_sub[35:32], o_pkt_sub[47:40], o_pkt_sub[55:48]};
            end
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= AUD_IDLE;
            emitIdx  <= 2'd0;
            emitMask <= 4'h0;
        end else begin
            state   <= stateNxt;
            emitIdx <= (state == AUD_EMIT) ? emitIdx + 2'd1 : 2'd0;
            if (state == AUD_IDLE && audStart) begin
                emitMask <= o_pkt_header[11:8] & o_sub_ok;
            end
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            AUD_IDLE: if (audStart) stateNxt = AUD_EMIT;
            AUD_EMIT: if (emitIdx == 2'd3) stateNxt = AUD_IDLE;
            default:  stateNxt = AUD_IDLE;
        endcase
    end

    // Samples are read from the held packet registers, which stay stable for
    // the whole scan because packets are at least 32 cycles apart.
    always_comb begin
        o_audio_valid = 1'b0;
        o_audio_l     = 16'h0000;
        o_audio_r     = 16'h0000;
        if (state == AUD_EMIT && emitMask[emitIdx]) begin
            o_audio_valid = 1'b1;
            o_audio_l     = o_pkt_sub[subBase + 8'd8 +: 16];
            o_audio_r     = o_pkt_sub[subBase + 8'd32 +: 16];
        end
    end
`else
    assign o_acr_valid   = 1'b0;
    assign o_cts         = '0;
    assign o_n           = '0;
    assign o_audio_valid = 1'b0;
    assign o_audio_l     = '0;
    assign o_audio_r     = '0;
`endif

endmodule

// File: tb/tb_hdmi_data_island_rx.sv
// Randomised scoreboard bench for hdmi_data_island_rx.
// Stimulus pushes expected packets/strobes with their arrival cycle; a negedge monitor pops and compares.
// No backpressure exists on the DUT; every output is a strobe checked when it appears.
module tb_hdmi_data_island_rx;

    logic         i_pixclk;
    logic         i_reset_n;
    logic         i_data;
    logic [3:0]   i_d0, i_d1, i_d2;
    logic         o_hsync, o_vsync, o_pkt_valid, o_hdr_ok, o_pkt_drop;
    logic [23:0]  o_pkt_header;
    logic [223:0] o_pkt_sub;
    logic [3:0]   o_sub_ok;
    logic         o_acr_valid, o_audio_valid;
    logic [19:0]  o_cts, o_n;
    logic [15:0]  o_audio_l, o_audio_r;

    hdmi_data_island_rx dut (
        .i_pixclk(i_pixclk), .i_reset_n(i_reset_n), .i_data(i_data),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2),
        .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_pkt_valid(o_pkt_valid), .o_pkt_header(o_pkt_header), .o_pkt_sub(o_pkt_sub),
        .o_hdr_ok(o_hdr_ok), .o_sub_ok(o_sub_ok), .o_pkt_drop(o_pkt_drop),
        .o_acr_valid(o_acr_valid), .o_cts(o_cts), .o_n(o_n),
        .o_audio_valid(o_audio_valid), .o_audio_l(o_audio_l), .o_audio_r(o_audio_r)
    );

    typedef struct {
        int           cyc;
        logic [23:0]  hdr;
        logic [223:0] sub;
        logic         hok;
        logic [3:0]   sok;
    } pktExp_t;
    typedef struct { int cyc; logic [19:0] cts; logic [19:0] n; } acrExp_t;
    typedef struct { int cyc; logic [15:0] l; logic [15:0] r; } audExp_t;

    pktExp_t pktQ[$];
    acrExp_t acrQ[$];
    audExp_t audQ[$];
    int      dropQ[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   monOn = 0;
    logic [1:0] expSync;

    initial begin
        i_pixclk = 1'b0;
        forever #5 i_pixclk = ~i_pixclk;
    end

    always @(posedge i_pixclk) cyc <= cyc + 1;

    // Sync outputs follow the last nibble seen inside an island.
    always @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) expSync <= 2'b00;
        else if (i_data) expSync <= {i_d0[0], i_d0[1]};
    end

    task automatic checkEq(input string name, input logic [223:0] act, input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    pktExp_t pe;
    acrExp_t ae;
    audExp_t ue;
    int      de;

    always @(negedge i_pixclk) begin
        if (monOn) begin
            checkEq("sync", {o_hsync, o_vsync}, expSync);
            if (o_pkt_valid) begin
                if (pktQ.size() == 0) checkEq("pkt_unexpected", o_pkt_valid, 1'b0);
                else begin
                    pe = pktQ.pop_front();
                    checkEq("pkt_cycle", cyc, pe.cyc);
                    checkEq("pkt_header", o_pkt_header, pe.hdr);
                    checkEq("pkt_sub", o_pkt_sub, pe.sub);
                    checkEq("hdr_ok", o_hdr_ok, pe.hok);
                    checkEq("sub_ok", o_sub_ok, pe.sok);
                end
            end
            if (o_pkt_drop) begin
                if (dropQ.size() == 0) checkEq("drop_unexpected", o_pkt_drop, 1'b0);
                else begin
                    de = dropQ.pop_front();
                    checkEq("drop_cycle", cyc, de);
                end
            end
            if (o_acr_valid) begin
                if (acrQ.size() == 0) checkEq("acr_unexpected", o_acr_valid, 1'b0);
                else begin
                    ae = acrQ.pop_front();
                    checkEq("acr_cycle", cyc, ae.cyc);
                    checkEq("acr_cts", o_cts, ae.cts);
                    checkEq("acr_n", o_n, ae.n);
                end
            end
            if (o_audio_valid) begin
                if (audQ.size() == 0) checkEq("audio_unexpected", o_audio_valid, 1'b0);
                else begin
                    ue = audQ.pop_front();
                    checkEq("audio_cycle", cyc, ue.cyc);
                    checkEq("audio_l", o_audio_l, ue.l);
                    checkEq("audio_r", o_audio_r, ue.r);
                end
            end
        end
    end

    // Parity that makes the whole codeword divide out: at each parity step
    // choose the bit that cancels the feedback, so the register shifts to zero.
    function automatic logic [7:0] bchParity(input logic [63:0] data, input int n);
        logic [7:0] c = 8'h00;
        logic [7:0] par;
        for (int i = 0; i < n; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? 8'hC1 : 8'h00);
        for (int j = 0; j < 8; j++) begin
            par[j] = c[7];
            c = {c[6:0], 1'b0};
        end
        return par;
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] r = {$urandom, $urandom};
        return r[55:0];
    endfunction

    task automatic drv(input logic dat, input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
        @(posedge i_pixclk);
        #1;
        i_data = dat; i_d0 = d0; i_d1 = d1; i_d2 = d2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // flipBlk: -1 none, 0 header, 1..4 subpacket flipBlk-1.
    task automatic sendPkt(input logic [23:0] hdr, input logic [55:0] s0, input logic [55:0] s1,
                           input logic [55:0] s2, input logic [55:0] s3, input int flipBlk,
                           input int flipBit, input int len, input bit dropExp);
        logic [55:0] sd[4];
        logic [63:0] ss[4];
        logic [31:0] hs;
        logic [3:0]  d1, d2;
        pktExp_t     e;
        acrExp_t     a;
        audExp_t     u;
        logic [7:0]  sb[7];
        sd[0] = s0; sd[1] = s1; sd[2] = s2; sd[3] = s3;
        hs = {bchParity({40'h0, hdr}, 24), hdr};
        for (int k = 0; k < 4; k++) ss[k] = {bchParity({8'h0, sd[k]}, 56), sd[k]};
        if (flipBlk == 0) hs[flipBit] = ~hs[flipBit];
        else if (flipBlk > 0) ss[flipBlk-1][flipBit] = ~ss[flipBlk-1][flipBit];
        for (int p = 0; p < len; p++) begin
            for (int k = 0; k < 4; k++) begin
                d1[k] = ss[k][2*p];
                d2[k] = ss[k][2*p+1];
            end
            drv(1'b1, {p != 0, hs[p], 1'($urandom), 1'($urandom)}, d1, d2);
            if (p == 31) begin
                e.cyc = cyc + 1;
                e.hdr = hs[23:0];
                e.sub = {ss[3][55:0], ss[2][55:0], ss[1][55:0], ss[0][55:0]};
                e.hok = (flipBlk != 0);
                for (int k = 0; k < 4; k++) e.sok[k] = (flipBlk != k + 1);
                pktQ.push_back(e);
`ifdef HDMI_DI_AUDIO_EXTRACT_EN
                for (int j = 0; j < 7; j++) sb[j] = ss[0][8*j +: 8];
                if (e.hdr[7:0] == 8'h01 && e.hok && e.sok[0]) begin
                    a.cyc = cyc + 2;
                    a.cts = {sb[1][3:0], sb[2], sb[3]};
                    a.n   = {sb[4][3:0], sb[5], sb[6]};
                    acrQ.push_back(a);
                end
                if (e.hdr[7:0] == 8'h02 && e.hok)
                    for (int k = 0; k < 4; k++)
                        if (e.hdr[8+k] && e.sok[k]) begin
                            u.cyc = cyc + 2 + k;
                            u.l = ss[k][23:8];
                            u.r = ss[k][47:32];
                            audQ.push_back(u);
                        end
`endif
            end
        end
        if (len < 32 && dropExp) dropQ.push_back(cyc + 2);
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_pkt_valid"}, o_pkt_valid, 1'b0);
        checkEq({tag, "_pkt_drop"}, o_pkt_drop, 1'b0);
        checkEq({tag, "_header"}, o_pkt_header, 24'h0);
        checkEq({tag, "_sub"}, o_pkt_sub, 224'h0);
        checkEq({tag, "_hdr_ok"}, o_hdr_ok, 1'b0);
        checkEq({tag, "_sub_ok"}, o_sub_ok, 4'h0);
        checkEq({tag, "_sync"}, {o_hsync, o_vsync}, 2'b00);
        checkEq({tag, "_acr"}, {o_acr_valid, o_cts, o_n}, 41'h0);
        checkEq({tag, "_audio"}, {o_audio_valid, o_audio_l, o_audio_r}, 33'h0);
    endtask

    localparam logic [19:0] ACR_N   = 20'd6144;
    localparam logic [19:0] ACR_CTS = 20'd74250;

    initial begin
        logic [55:0] acrSub;
        logic [23:0] hdr;
        int          kind, flipBlk, flipBit, len;
        i_reset_n = 1'b0; i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
        repeat (3) @(posedge i_pixclk);
        #1 i_reset_n = 1'b1;
        @(negedge i_pixclk);
        checkResetState("reset");
        monOn = 1;
        idle(2);

        // AVI infoframe, clean.
        sendPkt(24'h0D0282, 56'h191046, rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        idle(4);
        // ACR with N=6144, CTS=74250 (SB6..SB0).
        acrSub = {ACR_N[7:0], ACR_N[15:8], {4'h0, ACR_N[19:16]},
                  ACR_CTS[7:0], ACR_CTS[15:8], {4'h0, ACR_CTS[19:16]}, 8'h00};
        sendPkt({8'h00, 8'h00, 8'h01}, acrSub, rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        idle(4);
`ifdef HDMI_DI_AUDIO_EXTRACT_EN
        checkEq("acr_cts_74250", o_cts, ACR_CTS);
        checkEq("acr_n_6144", o_n, ACR_N);
`endif
        // Audio, samples in sub0 and sub2.
        sendPkt({8'h00, 8'h05, 8'h02}, {8'h00, 16'hABCD, 8'h00, 16'h1234, 8'h00}, rnd56(),
                {8'h00, 16'h7FFF, 8'h00, 16'h8000, 8'h00}, rnd56(), -1, 0, 32, 0);
        idle(6);
        // Audio with a flipped data bit in sub1: only sub0 survives.
        sendPkt({8'h00, 8'h03, 8'h02}, rnd56(), rnd56(), rnd56(), rnd56(), 2, 20, 32, 0);
        idle(6);
        // Island ends at pos 17, then a clean packet.
        sendPkt(24'h0D0282, rnd56(), rnd56(), rnd56(), rnd56(), -1, 0, 17, 1);
        idle(3);
        sendPkt(24'h0D0282, rnd56(), rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        idle(3);
        // Two back-to-back packets in one island.
        sendPkt({8'h00, 8'h0F, 8'h02}, rnd56(), rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        sendPkt({8'h00, 8'h00, 8'h01}, acrSub, rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        idle(6);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: hdr = {8'($urandom), 8'($urandom), 8'h01};
                1: hdr = {8'($urandom), 8'($urandom), 8'h02};
                2: hdr = 24'h0D0282;
                default: hdr = 24'($urandom);
            endcase
            flipBlk = -1; flipBit = 0;
            if ($urandom_range(0, 3) == 0) begin
                flipBlk = $urandom_range(0, 4);
                flipBit = $urandom_range(0, (flipBlk == 0) ? 31 : 63);
            end
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 32;
            sendPkt(hdr, rnd56(), rnd56(), rnd56(), rnd56(), flipBlk, flipBit, len, len < 32);
            idle($urandom_range(0, 3));
        end
        idle(8);

        // Reset in the middle of a packet: silent discard, everything back to zero.
        sendPkt(24'h0D0282, rnd56(), rnd56(), rnd56(), rnd56(), -1, 0, 10, 0);
        #2;
        i_reset_n = 1'b0;
        i_data = 1'b0;
        repeat (3) @(posedge i_pixclk);
        #1 i_reset_n = 1'b1;
        @(negedge i_pixclk);
        checkResetState("midreset");
        sendPkt({8'h00, 8'h01, 8'h02}, rnd56(), rnd56(), rnd56(), rnd56(), -1, 0, 32, 0);
        idle(8);

`ifndef HDMI_DI_AUDIO_EXTRACT_EN
        checkEq("disabled_acr_tied", {o_cts, o_n}, 40'h0);
`endif
        checkEq("pkt_queue_drained", pktQ.size(), 0);
        checkEq("drop_queue_drained", dropQ.size(), 0);
        checkEq("acr_queue_drained", acrQ.size(), 0);
        checkEq("audio_queue_drained", audQ.size(), 0);
        monOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_data_island_rx.md
# hdmi_data_island_rx

Receive-side data-island packet decoder for the HDMI path. Consumes the TERC4-decoded 4-bit nibbles of channels 0–2 during data-island periods and reassembles 32-cycle packets: 24-bit header plus four 56-bit subpackets. Checks every BCH block and publishes each packet with per-block status. Extracts Audio Clock Regeneration N/CTS values and 16-bit L/R PCM samples from audio sample packets for the downstream audio recovery logic.

## Interface
Parameters:
- PKT_LEN, 32, cycles per packet; fixed by protocol, not to be overridden.

Ports:
- i_pixclk  in  1  pixel clock; the only clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_data  in  1  data-island period active, aligned with nibbles
- i_d0  in  4  channel 0 nibble: [0]=HSYNC, [1]=VSYNC, [2]=header bit, [3]=not-first-cycle flag
- i_d1  in  4  channel 1 nibble: bit k = even bit of subpacket k
- i_d2  in  4  channel 2 nibble: bit k = odd bit of subpacket k
- o_hsync, o_vsync  out  1  registered i_d0[0], i_d0[1] while i_data=1; hold last value otherwise
- o_pkt_valid  out  1  one-cycle strobe: new packet on o_pkt_*
- o_pkt_header  out  24  HB0..HB2, HB0 in [7:0]
- o_pkt_sub  out  224  subpacket k in [56k+55:56k]
- o_hdr_ok  out  1  header BCH syndrome zero
- o_sub_ok  out  4  per-subpacket BCH syndrome zero
- o_pkt_drop  out  1  one-cycle strobe: partial packet discarded
- o_acr_valid  out  1  strobe: o_cts/o_n updated
- o_cts, o_n  out  20 each  last ACR values
- o_audio_valid  out  1  strobe: one L/R sample on o_audio_l/o_audio_r
- o_audio_l, o_audio_r  out  16 each  PCM sample

## Operation
- Bit position counter pos[4:0]:
  - Cleared when i_data=0.
  - Set to 0 on the first cycle with i_data=1, and on any cycle with i_data=1 and i_d0[3]=0 (resync).
  - Otherwise incremented each cycle, wrapping 31→0. Back-to-back packets are therefore contiguous.
- Header bits: at pos p, i_d0[2] is header bit p. Bits 0–23 are data, shifted LSB-first into the header register; bits 24–31 are parity.
- Subpacket k bits: at pos p, i_d1[k] is bit 2p and i_d2[k] is bit 2p+1. Bits 0–55 are data; bits 56–63 are parity.
- BCH check: LFSR step c' = (c<<1) ^ ((c[7]^b) ? 8'hC1 : 0), applied over all 32 header bits or 64 subpacket bits, parity bits included. Syndrome zero means ok. Each LFSR is cleared at pos 0. Subpackets take two steps per cycle (even bit first). Detection only, no correction.
- Packet completion: the cycle sampled at pos 31 with i_data=1 completes a packet.
  - Next cycle: o_pkt_valid=1; o_pkt_header, o_pkt_sub, o_hdr_ok and o_sub_ok are loaded and then held until the next completion.
- Partial packets: i_data falling at pos≠31, or a resync at pos≠0, discards the partial packet and gives o_pkt_drop=1 on the next cycle.
- ACR extraction: when HB0=8'h01, o_hdr_ok=1 and o_sub_ok[0]=1, using subpacket 0 bytes SB0..SB6 at [8j+7:8j]:
  - o_cts = {SB1[3:0],SB2,SB3}
  - o_n = {SB4[3:0],SB5,SB6}
  - o_acr_valid pulses in the cycle after o_pkt_valid.
- Audio extraction (FSM IDLE→EMIT→IDLE):
  - Entry: when HB0=8'h02 and o_hdr_ok=1, the present mask is HB1[3:0] & o_sub_ok.
  - EMIT scans k=0..3, one cycle per k. For each set bit it outputs o_audio_l = sub_k[23:8] and o_audio_r = sub_k[47:32] with o_audio_valid=1.
  - EMIT lasts exactly 4 cycles, then returns to IDLE.
  - A packet completing during EMIT is impossible (32-cycle spacing). Reset mid-EMIT returns the FSM to IDLE.

## Timing
- Reset values: all strobes 0, all data outputs 0, o_hdr_ok=0, o_sub_ok=0, FSM IDLE, pos 0, LFSRs 0.
- Latency:
  - o_hsync/o_vsync: 1 cycle.
  - o_pkt_valid: 1 cycle after pos 31.
  - o_acr_valid: 2 cycles after pos 31.
  - o_audio_valid for subpacket k: 2+k cycles after pos 31.
- Reset assertion mid-packet discards the partial packet silently, with no o_pkt_drop.

## Configuration
- HDMI_DI_AUDIO_EXTRACT_EN defined: ACR and audio extraction plus the EMIT FSM are built.
- Not defined: o_acr_valid, o_audio_valid, o_cts, o_n, o_audio_l and o_audio_r are tied to 0; packet decoding is unchanged.

## Structure
- Package hdmi_di_pkg holds:
  - packet type constants: ACR 8'h01, AUDIO 8'h02, AVI 8'h82, AIF 8'h84
  - BCH polynomial 8'hC1
  - function bch_step(code, bit)
- Sub-module hdmi_bch_syndrome holds one LFSR lane: inputs clr, en, two bits, dual-bit select; output syndrome.
  - Instantiated once in 1-bit mode for the header and four times in 2-bit mode for the subpackets.

## Test plan
- AVI infoframe, HB 0D0282, SB0 56'h191046, correct parity → o_pkt_valid once, o_hdr_ok=1, o_sub_ok=4'hF, payload matches exactly.
- ACR packet with N=6144 and CTS=74250 → o_acr_valid, o_n=20'd6144, o_cts=20'd74250.
- Audio packet, HB1[3:0]=4'b0101, L/R = 16'h1234/16'hABCD in sub0 and 16'h8000/16'h7FFF in sub2 → two o_audio_valid pulses, 2 cycles apart, correct values.
- Single bit flipped in subpacket 1 of an audio packet with HB1[3:0]=4'b0011 → o_sub_ok=4'b1101; only the sub0 sample is emitted.
- i_data dropped at pos 17 → o_pkt_drop pulse, no o_pkt_valid; the next full packet decodes cleanly.
- Two back-to-back packets in one 64-cycle island → two o_pkt_valid pulses, 32 cycles apart.
